// File: rtl/matrix_stream_rx_if.sv
// rtl/matrix_stream_rx_if.sv - CPU matrix byte stream, buffer read port and status for matrix_stream_rx
// master = CPU / consumer side, slave = matrix_stream_rx.
interface matrix_stream_rx_if #(
  parameter int MAX_ROWS = 16,
  parameter int MAX_COLS = 16,
  parameter int DATA_W   = 8
);
  localparam int RW  = $clog2(MAX_ROWS + 1);
  localparam int CW  = $clog2(MAX_COLS + 1);
  localparam int RIW = $clog2(MAX_ROWS);
  localparam int CIW = $clog2(MAX_COLS);

  logic [DATA_W-1:0] in_matrix;
  logic              in_matrix_en;
  logic              in_matrix_end_row;
  logic              in_matrix_end;
  logic              matrix_valid;
  logic [RW-1:0]     matrix_rows;
  logic [CW-1:0]     matrix_cols;
  logic [RIW-1:0]    rd_row;
  logic [CIW-1:0]    rd_col;
  logic [DATA_W-1:0] rd_data;
  logic              rd_release;
  logic              err_ragged;
  logic              err_overflow;
  logic              err_overrun;

  modport master (
    output in_matrix, in_matrix_en, in_matrix_end_row, in_matrix_end,
    output rd_row, rd_col, rd_release,
    input  matrix_valid, matrix_rows, matrix_cols, rd_data,
    input  err_ragged, err_overflow, err_overrun
  );

  modport slave (
    input  in_matrix, in_matrix_en, in_matrix_end_row, in_matrix_end,
    input  rd_row, rd_col, rd_release,
    output matrix_valid, matrix_rows, matrix_cols, rd_data,
    output err_ragged, err_overflow, err_overrun
  );
endinterface

// File: rtl/matrix_stream_rx.sv
// rtl/matrix_stream_rx.sv - captures one matrix from the CPU byte stream and holds it for a reader
// Strobes in one cycle are applied in the order en, end_row, end.
module matrix_stream_rx #(
  parameter int MAX_ROWS = 16,
  parameter int MAX_COLS = 16,
  parameter int DATA_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  matrix_stream_rx_if.slave   bus
);
  localparam int RW    = $clog2(MAX_ROWS + 1);
  localparam int CW    = $clog2(MAX_COLS + 1);
  localparam int DEPTH = MAX_ROWS * MAX_COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [RW-1:0] ROW_LIM = RW'(MAX_ROWS);
  localparam logic [CW-1:0] COL_LIM = CW'(MAX_COLS);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_HOLD} state_t;

  state_t            r_state,        w_state_nxt;
  logic [RW-1:0]     r_row_cnt,      w_row_nxt;
  logic [CW-1:0]     r_col_cnt,      w_col_nxt;
  logic [CW-1:0]     r_ref_cols,     w_ref_nxt;
  logic [RW-1:0]     r_matrix_rows,  w_rows_nxt;
  logic [CW-1:0]     r_matrix_cols,  w_cols_nxt;
  logic              r_valid,        w_valid_nxt;
  logic              r_err_ragged,   w_rag_nxt;
  logic              r_err_overflow, w_ovf_nxt;
  logic              r_err_overrun,  w_ovr_nxt;
  logic              w_we;
  logic [AW-1:0]     w_wr_addr;
  logic [AW-1:0]     w_rd_addr;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_mem [DEPTH];

  assign w_wr_addr = AW'(r_row_cnt) * AW'(MAX_COLS) + AW'(r_col_cnt);
  assign w_rd_addr = AW'(bus.rd_row) * AW'(MAX_COLS) + AW'(bus.rd_col);

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row_cnt;
    w_col_nxt   = r_col_cnt;
    w_ref_nxt   = r_ref_cols;
    w_rows_nxt  = r_matrix_rows;
    w_cols_nxt  = r_matrix_cols;
    w_valid_nxt = r_valid;
    w_rag_nxt   = r_err_ragged;
    w_ovf_nxt   = r_err_overflow;
    w_ovr_nxt   = r_err_overrun;
    w_we        = 1'b0;

    unique case (r_state)
      // Counters are zero in IDLE, so IDLE shares the RECV datapath.
      S_IDLE, S_RECV: begin
        if (bus.in_matrix_en) begin
          if (r_row_cnt == ROW_LIM || r_col_cnt == COL_LIM) begin
            w_ovf_nxt = 1'b1;
          end else begin
            w_we      = 1'b1;
            w_col_nxt = r_col_cnt + CW'(1);
          end
        end
        // end closes an open row implicitly; an empty row is never closed.
        if ((bus.in_matrix_end_row || bus.in_matrix_end) && w_col_nxt != '0) begin
          if (r_row_cnt == '0) begin
            w_ref_nxt = w_col_nxt;
          end else if (w_col_nxt != r_ref_cols) begin
            w_rag_nxt = 1'b1;
          end
          if (r_row_cnt != ROW_LIM) begin
            w_row_nxt = r_row_cnt + RW'(1);
          end
          w_col_nxt = '0;
        end
        if (bus.in_matrix_end) begin
          if (w_row_nxt == '0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_HOLD;
            w_valid_nxt = 1'b1;
            w_rows_nxt  = w_row_nxt;
            w_cols_nxt  = w_ref_nxt;
          end
        end else if (r_state == S_IDLE && bus.in_matrix_en) begin
          w_state_nxt = S_RECV;
        end
      end
      S_HOLD: begin
        if (bus.in_matrix_en) begin
          w_ovr_nxt = 1'b1;
        end
        if (bus.rd_release) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
          w_ref_nxt   = '0;
          w_rag_nxt   = 1'b0;
          w_ovf_nxt   = 1'b0;
          w_ovr_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_row_cnt      <= '0;
      r_col_cnt      <= '0;
      r_ref_cols     <= '0;
      r_matrix_rows  <= '0;
      r_matrix_cols  <= '0;
      r_valid        <= 1'b0;
      r_err_ragged   <= 1'b0;
      r_err_overflow <= 1'b0;
      r_err_overrun  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_row_cnt      <= w_row_nxt;
      r_col_cnt      <= w_col_nxt;
      r_ref_cols     <= w_ref_nxt;
      r_matrix_rows  <= w_rows_nxt;
      r_matrix_cols  <= w_cols_nxt;
      r_valid        <= w_valid_nxt;
      r_err_ragged   <= w_rag_nxt;
      r_err_overflow <= w_ovf_nxt;
      r_err_overrun  <= w_ovr_nxt;
    end
  end

  // Buffer has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_wr_addr] <= bus.in_matrix;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[w_rd_addr];
    end
  end

  assign bus.matrix_valid = r_valid;
  assign bus.matrix_rows  = r_matrix_rows;
  assign bus.matrix_cols  = r_matrix_cols;
  assign bus.rd_data      = r_rd_data;
  assign bus.err_ragged   = r_err_ragged;
  assign bus.err_overflow = r_err_overflow;
  assign bus.err_overrun  = r_err_overrun;
endmodule

// File: tb/tb_matrix_stream_rx.sv
// tb/tb_matrix_stream_rx.sv - directed table-driven bench for matrix_stream_rx
// Status word compared per step: {valid, rows[4:0], cols[4:0], ragged, overflow, overrun}.
module tb_matrix_stream_rx;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  matrix_stream_rx_if #(.MAX_ROWS(16), .MAX_COLS(16), .DATA_W(8)) bus ();

  matrix_stream_rx #(.MAX_ROWS(16), .MAX_COLS(16), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] d;
    logic       er;
    logic       e;
    logic       rel;
    logic [3:0] rr;
    logic [3:0] rc;
    logic       chk;
    logic [7:0] exp_rd;
    logic       v;
    logic [4:0] rows;
    logic [4:0] cols;
    logic [2:0] err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic en, input logic [7:0] d, input logic er, input logic e,
                              input logic rel, input logic [3:0] rr, input logic [3:0] rc,
                              input logic chk, input logic [7:0] exp_rd, input logic v,
                              input logic [4:0] rows, input logic [4:0] cols, input logic [2:0] err);
    vec_t t;
    t.en = en; t.d = d; t.er = er; t.e = e; t.rel = rel; t.rr = rr; t.rc = rc;
    t.chk = chk; t.exp_rd = exp_rd; t.v = v; t.rows = rows; t.cols = cols; t.err = err;
    return t;
  endfunction

  function automatic logic [31:0] status();
    return {18'd0, bus.matrix_valid, bus.matrix_rows, bus.matrix_cols,
            bus.err_ragged, bus.err_overflow, bus.err_overrun};
  endfunction

  function automatic logic [31:0] st(input logic v, input logic [4:0] rows, input logic [4:0] cols,
                                     input logic [2:0] err);
    return {18'd0, v, rows, cols, err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic [7:0] d, input logic er, input logic e,
                      input logic rel);
    bus.in_matrix         = d;
    bus.in_matrix_en      = en;
    bus.in_matrix_end_row = er;
    bus.in_matrix_end     = e;
    bus.rd_release        = rel;
    @(posedge clk);
    #1;
    bus.in_matrix_en      = 1'b0;
    bus.in_matrix_end_row = 1'b0;
    bus.in_matrix_end     = 1'b0;
    bus.rd_release        = 1'b0;
  endtask

  task automatic rd(input logic [3:0] r, input logic [3:0] c, output logic [7:0] q);
    bus.rd_row = r;
    bus.rd_col = c;
    @(posedge clk);
    #1;
    q = bus.rd_data;
  endtask

  logic [7:0] q;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    bus.in_matrix = '0; bus.in_matrix_en = 0; bus.in_matrix_end_row = 0; bus.in_matrix_end = 0;
    bus.rd_row = '0; bus.rd_col = '0; bus.rd_release = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset status", status(), 32'd0);
    check("reset rd_data", {24'd0, bus.rd_data}, 32'd0);
    reset = 1'b0;

    // IDLE ignores lone end_row/end/release
    vq.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
    vq.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
    vq.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000));
    // 2x3 matrix 1..6
    vq.push_back(mk(1, 8'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
    vq.push_back(mk(1, 8'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
    vq.push_back(mk(1, 8'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
    vq.push_back(mk(0, 8'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
    vq.push_back(mk(1, 8'd4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
    vq.push_back(mk(1, 8'd5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
    vq.push_back(mk(1, 8'd6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
    vq.push_back(mk(0, 8'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
    vq.push_back(mk(0, 8'd0, 0, 1, 0, 0, 0, 0, 0, 1, 2, 3, 3'b000));
    vq.push_back(mk(0, 8'd0, 0, 0, 0, 1, 2, 1, 8'd6, 1, 2, 3, 3'b000));
    vq.push_back(mk(0, 8'd0, 0, 0, 1, 0, 0, 1, 8'd1, 0, 2, 3, 3'b000));
    // ragged: 3 then 2 bytes
    vq.push_back(mk(1, 8'h11, 0, 0, 0, 0, 0, 0, 0, 0, 2, 3, 3'b000));
    vq.push_back(mk(1, 8'h12, 0, 0, 0, 0, 0, 0, 0, 0, 2, 3, 3'b000));
    vq.push_back(mk(1, 8'h13, 0, 0, 0, 0, 0, 0, 0, 0, 2, 3, 3'b000));
    vq.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 2, 3, 3'b000));
    vq.push_back(mk(1, 8'h21, 0, 0, 0, 0, 0, 0, 0, 0, 2, 3, 3'b000));
    vq.push_back(mk(1, 8'h22, 0, 0, 0, 0, 0, 0, 0, 0, 2, 3, 3'b000));
    vq.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 2, 3, 3'b100));
    vq.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1, 2, 3, 3'b100));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, 1, 8'h22, 1, 2, 3, 3'b100));
    vq.push_back(mk(0, 8'h00, 0, 0, 1, 0, 2, 1, 8'h13, 0, 2, 3, 3'b000));

    foreach (vq[i]) begin
      bus.rd_row = vq[i].rr;
      bus.rd_col = vq[i].rc;
      step(vq[i].en, vq[i].d, vq[i].er, vq[i].e, vq[i].rel);
      check($sformatf("vec%0d status", i), status(), st(vq[i].v, vq[i].rows, vq[i].cols, vq[i].err));
      if (vq[i].chk) check($sformatf("vec%0d rd_data", i), {24'd0, bus.rd_data}, {24'd0, vq[i].exp_rd});
    end

    // overflow: 17 bytes in one row
    for (int i = 1; i <= 17; i++) step(1, 8'(i), 0, 0, 0);
    check("ovf pre-end", status(), st(0, 2, 3, 3'b010));
    step(0, 0, 0, 1, 0);
    check("ovf end", status(), st(1, 1, 16, 3'b010));
    rd(0, 15, q); check("ovf (0,15)", {24'd0, q}, 32'd16);

    // overrun while held
    step(1, 8'hAA, 0, 0, 0);
    check("overrun", status(), st(1, 1, 16, 3'b011));
    rd(0, 15, q); check("overrun (0,15)", {24'd0, q}, 32'd16);
    rd(1, 0, q);  check("overrun (1,0)", {24'd0, q}, 32'h21);
    step(0, 0, 1, 1, 0);
    check("hold ignores end", status(), st(1, 1, 16, 3'b011));
    step(0, 0, 0, 0, 1);
    check("release clears", status(), st(0, 1, 16, 3'b000));
    step(1, 8'h55, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    check("1x1 status", status(), st(1, 1, 1, 3'b000));
    rd(0, 0, q); check("1x1 (0,0)", {24'd0, q}, 32'h55);
    step(0, 0, 0, 0, 1);

    // implicit close
    step(1, 8'd7, 0, 0, 0);
    step(1, 8'd8, 0, 0, 0);
    check("implicit pre-end", status(), st(0, 1, 1, 3'b000));
    step(0, 0, 0, 1, 0);
    check("implicit end", status(), st(1, 1, 2, 3'b000));
    rd(0, 1, q); check("implicit (0,1)", {24'd0, q}, 32'd8);
    step(0, 0, 0, 0, 1);

    // en + end_row + end in one cycle
    step(1, 8'h03, 0, 0, 0);
    step(1, 8'h09, 1, 1, 0);
    check("simul status", status(), st(1, 1, 2, 3'b000));
    rd(0, 1, q); check("simul (0,1)", {24'd0, q}, 32'h09);
    step(0, 0, 0, 0, 1);

    // 17 one-byte rows saturate at 16
    for (int i = 1; i <= 17; i++) begin
      step(1, 8'(8'h40 + i), 0, 0, 0);
      step(0, 0, 1, 0, 0);
    end
    step(0, 0, 0, 1, 0);
    check("row ovf status", status(), st(1, 16, 1, 3'b010));
    rd(15, 0, q); check("row ovf (15,0)", {24'd0, q}, 32'h50);
    step(0, 0, 0, 0, 1);

    // reset mid-RECV
    for (int i = 0; i < 4; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
    #2 reset = 1'b1;
    #1 check("async reset", status(), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(0, 0, 0, 1, 0);
    check("post-reset no valid", status(), 32'd0);
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    check("fresh 1x2", status(), st(1, 1, 2, 3'b000));
    rd(0, 1, q); check("fresh (0,1)", {24'd0, q}, 32'h22);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_stream_rx.md
Name: matrix_stream_rx

Overview:
- Receiving end of the CPU matrix output stream: the byte bus with data-enable, end-of-row and end-of-matrix strobes.
- Captures one matrix of bytes into an internal buffer and tracks its row/column geometry.
- Flags malformed streams.
- Presents the completed matrix through a synchronous read port until the consumer releases it. Sits between the CPU subsystem and downstream compute/display logic.

Parameters:
- MAX_ROWS, 16, maximum rows per matrix.
- MAX_COLS, 16, maximum elements per row.
- DATA_W, 8, element width in bits.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- in_matrix  in  DATA_W  element byte from CPU.
- in_matrix_en  in  1  1-cycle strobe: in_matrix valid.
- in_matrix_end_row  in  1  1-cycle strobe: current row complete.
- in_matrix_end  in  1  1-cycle strobe: matrix complete.
- matrix_valid  out  1  buffer holds a complete matrix.
- matrix_rows  out  clog2(MAX_ROWS+1)  row count of held matrix.
- matrix_cols  out  clog2(MAX_COLS+1)  column count of held matrix.
- rd_row  in  clog2(MAX_ROWS)  read row index.
- rd_col  in  clog2(MAX_COLS)  read column index.
- rd_data  out  DATA_W  element at (rd_row, rd_col), registered.
- rd_release  in  1  consumer done; frees buffer.
- err_ragged  out  1  sticky: row length differed from first row.
- err_overflow  out  1  sticky: row/column limit exceeded.
- err_overrun  out  1  sticky: data arrived while buffer held.

Behaviour:
- Decided: one clock; reset is asynchronous and active-high.
- On reset all outputs are 0, state is IDLE, and all counters are cleared.
- Buffer contents are undefined after reset.
- Buffer is MAX_ROWS*MAX_COLS entries, addressed row*MAX_COLS+col.
- States: IDLE, RECV, HOLD.
- IDLE:
  - in_matrix_en writes element (0,0), sets col_cnt=1 and moves to RECV.
  - end_row or end alone is ignored.
- RECV:
  - in_matrix_en writes at (row_cnt, col_cnt), then col_cnt++.
  - If col_cnt==MAX_COLS or row_cnt==MAX_ROWS, the element is dropped and err_overflow is set.
- end_row with col_cnt>0:
  - Closes the row and latches row 0 width as ref_cols.
  - Later rows with col_cnt!=ref_cols set err_ragged.
  - row_cnt++ and col_cnt=0.
- end_row with col_cnt==0 is ignored (no empty rows).
- end in RECV:
  - If col_cnt>0, the open row is first closed implicitly with the same checks.
  - matrix_rows = final row_cnt and matrix_cols = ref_cols.
  - matrix_valid goes high the cycle after end; state moves to HOLD.
  - An end that would produce 0 rows returns to IDLE without asserting matrix_valid.
- Simultaneous strobes in one cycle are processed in order en, end_row, end. The element lands in the current row before that row closes.
- HOLD:
  - Incoming en, end_row and end are dropped; en sets err_overrun.
  - rd_data = buffer[rd_row*MAX_COLS+rd_col], 1-cycle latency, valid in any state.
  - Out-of-range indices return undefined data with no side effects.
- rd_release in HOLD:
  - Next cycle matrix_valid=0 and state moves to IDLE; counters and ref_cols are cleared.
  - matrix_rows/cols retain their last values until the next end.
  - rd_release outside HOLD is ignored.
- Error flags are sticky. They clear only on reset or on rd_release, which clears all three.
- Reset asserted mid-RECV discards the partial matrix immediately (asynchronous). No matrix_valid follows.
- Counters saturate and never wrap.

Test Plan:
- 2x3 matrix: bytes 1..6 with end_row after every 3rd byte, then end -> matrix_valid one cycle after end, rows=2, cols=3; read (1,2) returns 6 one cycle later; all errors 0.
- Ragged: row0 = 3 bytes, row1 = 2 bytes, end -> matrix_valid=1, rows=2, cols=3, err_ragged=1; rd_release -> err_ragged=0, matrix_valid=0 next cycle.
- Overflow: 17 bytes in a single row with MAX_COLS=16, end -> cols=16, err_overflow=1, element (0,15) = 16th byte.
- Overrun: in HOLD send byte 0xAA -> err_overrun=1; buffer and rows/cols unchanged; after release, new 1x1 matrix 0x55 -> rd_data(0,0)=0x55.
- Implicit row close and simultaneous strobes: bytes 7,8 then end without end_row -> rows=1, cols=2. en(0x09)+end_row+end in one cycle from RECV with col_cnt=1 -> rows=1, cols=2, (0,1)=0x09.
- Reset mid-RECV after 4 bytes -> matrix_valid stays 0; a fresh 1x2 matrix afterwards reports rows=1, cols=2.
